// File: rtl/musa_pkg.sv
// musa_pkg: shared size/exception codes, FSM encoding and alignment helper for the MEM stage
package musa_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} mem_size_e;
  typedef enum logic {IDLE, ACCESS} state_e;
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;
  // reserved size 11 behaves as word, so it needs word alignment
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_BYTE) ? 1'b0 : (size == SZ_HALF) ? off[0] : (off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: req/ack data-memory bus between the MEM stage and memory
interface mem_stage_if;
  logic mem_req;
  logic mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_be;
  logic mem_ack;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_stage_align.sv
// mem_align: byte-lane enables, store replication and load extract/extend
module mem_align
  import musa_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] sd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    be = (size == SZ_BYTE) ? 4'b0001 << off : (size == SZ_HALF) ? 4'b0011 << off : 4'b1111;
    wdata = (size == SZ_BYTE) ? {4{sd[7:0]}} : (size == SZ_HALF) ? {2{sd[15:0]}} : sd;
    ldata = (size == SZ_BYTE) ? {{24{~uns & b[7]}}, b} :
            (size == SZ_HALF) ? {{16{~uns & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; req/ack memory access with timeout, load alignment, MEM/WB registers
module mem_stage
  import musa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  mem_stage_if.master mem,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [1:0]  wb_exc
);
  state_e state, state_n;
  logic [7:0] cnt;
  logic [31:0] addr_q, sd_q, ldata, wdata;
  logic [1:0] size_q;
  logic uns_q, we_q, rw_q;
  logic [4:0] rd_q;
  logic [3:0] be;
  logic mem_op, mis, accept, timeout, req;
  mem_align u_align (
    .size(size_q), .uns(uns_q), .off(addr_q[1:0]), .sd(sd_q), .rdata(mem.mem_rdata),
    .be(be), .wdata(wdata), .ldata(ldata)
  );
  always_comb begin
    mem_op = valid_in & (mem_read | mem_write);
    mis = misaligned(mem_size, alu_result[1:0]);
    accept = (state == IDLE) & mem_op & ~mis;
    req = state == ACCESS;
    timeout = req & ~mem.mem_ack & (cnt == 8'(TIMEOUT_CYCLES - 1));
    state_n = (state == IDLE) ? (accept ? ACCESS : IDLE) : ((mem.mem_ack | timeout) ? IDLE : ACCESS);
    stall = reset & ((state == IDLE) ? accept : ~(mem.mem_ack | timeout));
  end
  assign mem.mem_req = req;
  assign mem.mem_we = req & we_q;
  assign mem.mem_addr = req ? {addr_q[31:2], 2'b00} : '0;
  assign mem.mem_wdata = req ? wdata : '0;
  assign mem.mem_be = req ? be : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      sd_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      we_q <= 1'b0;
      rw_q <= 1'b0;
      rd_q <= '0;
      wb_valid <= 1'b0;
      wb_data <= '0;
      wb_rd <= '0;
      wb_reg_write <= 1'b0;
      wb_exc <= EXC_NONE;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        cnt <= '0;
        addr_q <= alu_result;
        sd_q <= store_data;
        size_q <= mem_size;
        uns_q <= mem_unsigned;
        we_q <= mem_write;
        rd_q <= rd_in;
        rw_q <= reg_write_in;
        wb_valid <= valid_in & ~accept;
        wb_data <= alu_result;
        wb_rd <= rd_in;
        wb_reg_write <= valid_in & ~(mem_read | mem_write) & reg_write_in;
        wb_exc <= (mem_op & mis) ? EXC_MISALIGN : EXC_NONE;
      end else begin
        cnt <= cnt + 8'd1;
        wb_valid <= mem.mem_ack | timeout;
        wb_data <= (mem.mem_ack & ~we_q) ? ldata : addr_q;
        wb_rd <= rd_q;
        wb_reg_write <= mem.mem_ack & ~we_q & rw_q;
        wb_exc <= timeout ? EXC_TIMEOUT : EXC_NONE;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of ALU pass-through, loads/stores, misalignment, timeout and async reset
module tb_mem_stage;
  logic clk = 1'b0, reset = 1'b0;
  logic valid_in = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0, reg_write_in = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0;
  logic [1:0] mem_size = '0;
  logic [4:0] rd_in = '0;
  logic stall, wb_valid, wb_reg_write;
  logic [31:0] wb_data;
  logic [4:0] wb_rd;
  logic [1:0] wb_exc;
  int total = 0, bad = 0, stalls;
  mem_stage_if bus ();
  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result(alu_result), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem(bus.master), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_exc(wb_exc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r, input logic rw);
    valid_in = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    alu_result = a; store_data = sd; rd_in = r; reg_write_in = rw;
    #1;
  endtask
  task automatic idle_in();
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; alu_result = 32'h0000_0200;
  endtask
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    step(); step();
    chk("rst_req", bus.mem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b1;
    step();
    op(0, 0, 2'b10, 0, 32'h1234, 0, 5'd3, 1);
    chk("alu_stall", stall, 0);
    chk("alu_req", bus.mem_req, 0);
    step(); idle_in(); #1;
    chk("alu_wbv", wb_valid, 1);
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_rd", wb_rd, 3);
    chk("alu_rw", wb_reg_write, 1);
    chk("alu_stall2", stall, 0);
    step();
    chk("idle_wbv", wb_valid, 0);
    op(0, 1, 2'b00, 0, 32'h103, 32'hAB, 5'd4, 1);
    chk("sb_stall0", stall, 1);
    chk("sb_req0", bus.mem_req, 0);
    stalls = 0;
    step(); idle_in(); #1;
    chk("sb_req", bus.mem_req, 1);
    chk("sb_we", bus.mem_we, 1);
    chk("sb_addr", bus.mem_addr, 32'h100);
    chk("sb_be", bus.mem_be, 4'b1000);
    chk("sb_wdata", bus.mem_wdata, 32'hABABABAB);
    chk("sb_wbv", wb_valid, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      stalls += int'(stall);
    end
    step();
    chk("sb_hold_addr", bus.mem_addr, 32'h100);
    bus.mem_ack = 1'b1; #1;
    chk("sb_ack_stall", stall, 0);
    step(); bus.mem_ack = 1'b0; #1;
    chk("sb_stalls", stalls, 3);
    chk("sb_req_done", bus.mem_req, 0);
    chk("sb_wbv", wb_valid, 1);
    chk("sb_rw", wb_reg_write, 0);
    chk("sb_exc", wb_exc, 0);
    op(1, 0, 2'b00, 0, 32'h102, 0, 5'd5, 1);
    step(); idle_in(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0080_0000; #1;
    chk("lb_ack_stall", stall, 0);
    step(); bus.mem_ack = 1'b0;
    op(1, 0, 2'b00, 1, 32'h102, 0, 5'd6, 1);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    chk("lb_rw", wb_reg_write, 1);
    chk("lb_rd", wb_rd, 5);
    chk("lbu_accept", stall, 1);
    step(); idle_in(); bus.mem_ack = 1'b1; #1;
    step(); bus.mem_ack = 1'b0; #1;
    chk("lbu_data", wb_data, 32'h80);
    chk("lbu_rd", wb_rd, 6);
    op(0, 1, 2'b01, 0, 32'h102, 32'h1234BEEF, 5'd0, 0);
    step(); idle_in(); #1;
    chk("sh_be", bus.mem_be, 4'b1100);
    chk("sh_wdata", bus.mem_wdata, 32'hBEEFBEEF);
    bus.mem_ack = 1'b1;
    step(); bus.mem_ack = 1'b0; #1;
    op(1, 0, 2'b10, 0, 32'h102, 0, 5'd7, 1);
    chk("lw_mis_req", bus.mem_req, 0);
    chk("lw_mis_stall", stall, 0);
    step(); idle_in(); #1;
    chk("lw_mis_req1", bus.mem_req, 0);
    chk("lw_mis_wbv", wb_valid, 1);
    chk("lw_mis_exc", wb_exc, 2'b01);
    chk("lw_mis_rw", wb_reg_write, 0);
    chk("lw_mis_data", wb_data, 32'h102);
    op(1, 0, 2'b01, 0, 32'h104, 0, 5'd8, 1);
    step(); idle_in(); #1;
    chk("lh_to_req1", bus.mem_req, 1);
    step(); step(); step();
    chk("lh_to_req4", bus.mem_req, 1);
    chk("lh_to_stall4", stall, 0);
    step();
    chk("lh_to_req", bus.mem_req, 0);
    chk("lh_to_wbv", wb_valid, 1);
    chk("lh_to_exc", wb_exc, 2'b10);
    chk("lh_to_rw", wb_reg_write, 0);
    bus.mem_ack = 1'b1;
    step(); bus.mem_ack = 1'b0; #1;
    chk("late_ack_wbv", wb_valid, 0);
    chk("late_ack_req", bus.mem_req, 0);
    op(0, 1, 2'b10, 0, 32'h108, 32'hCAFEF00D, 5'd0, 0);
    step(); idle_in(); #1;
    chk("rstmid_req0", bus.mem_req, 1);
    #2 reset = 1'b0; #1;
    chk("rstmid_req", bus.mem_req, 0);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_data", wb_data, 0);
    chk("rstmid_exc", wb_exc, 0);
    step();
    reset = 1'b1;
    op(0, 1, 2'b10, 0, 32'h108, 32'hCAFEF00D, 5'd0, 0);
    step(); idle_in(); #1;
    chk("sw_addr", bus.mem_addr, 32'h108);
    chk("sw_be", bus.mem_be, 4'b1111);
    chk("sw_wdata", bus.mem_wdata, 32'hCAFEF00D);
    bus.mem_ack = 1'b1;
    step(); bus.mem_ack = 1'b0; #1;
    chk("sw_wbv", wb_valid, 1);
    chk("sw_exc", wb_exc, 0);
    chk("sw_rw", wb_reg_write, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
